wb_regfile: RTL and testbench

//  Write-back stage plus architectural register file of the 5-stage MIPS pipeline.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/regfile_core.sv | 43 ++++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: write-back source selects and well-known register indices.
package pipe_pkg;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b10,
    MTR_RSVD = 2'b11
  } mtr_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_core.sv
// 32x32 architectural register file: one write port, two combinational read ports,
// $0 hardwired to zero, $gp/$sp preset on synchronous active-low reset.
module regfile_core
  import pipe_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_03FC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_d[i] = '0;
      end
      regs_d[REG_GP] = GP_INIT;
      regs_d[REG_SP] = SP_INIT;
    end else if (we && (waddr != REG_ZERO)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: WB source mux, register-file commit with write-through
// bypass to the ID read ports, forwarding outputs and a committed-write counter.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_03FC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IMemData,
  input  logic [31:0]      IALUOut,
  input  logic [31:0]      IPCPlus4,
  input  logic [4:0]       IWriteReg,
  input  logic             ICRegWrite,
  input  logic [1:0]       ICMemtoReg,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [31:0]      ReadData1,
  output logic [31:0]      ReadData2,
  output logic [31:0]      WBData,
  output logic [4:0]       WBWriteReg,
  output logic             WBRegWrite,
  output logic [CNT_W-1:0] RetireCount
);

  logic [31:0]      wb_data;
  logic             wb_reg_write;
  logic [31:0]      core_rdata1;
  logic [31:0]      core_rdata2;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;

  always_comb begin
    case (mtr_e'(ICMemtoReg))
      MTR_MEM:  wb_data = IMemData;
      MTR_LINK: wb_data = IPCPlus4;
      default:  wb_data = IALUOut;
    endcase
  end

  // Gating with reset keeps a write on a reset edge out of the bypass and the counter.
  assign wb_reg_write = reset && ICRegWrite && (IWriteReg != REG_ZERO);

  regfile_core #(
    .SP_INIT (SP_INIT),
    .GP_INIT (GP_INIT)
  ) u_core (
    .clk    (clk),
    .rst_n  (reset),
    .we     (wb_reg_write),
    .waddr  (IWriteReg),
    .wdata  (wb_data),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (core_rdata1),
    .rdata2 (core_rdata2)
  );

  assign ReadData1 = (wb_reg_write && (ReadReg1 == IWriteReg)) ? wb_data : core_rdata1;
  assign ReadData2 = (wb_reg_write && (ReadReg2 == IWriteReg)) ? wb_data : core_rdata2;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (!reset) begin
      retire_cnt_d = '0;
    end else if (wb_reg_write) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    retire_cnt_q <= retire_cnt_d;
  end

  assign WBData      = wb_data;
  assign WBWriteReg  = IWriteReg;
  assign WBRegWrite  = wb_reg_write;
  assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array/counter reference model.
module tb_wb_regfile;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   IMemData, IALUOut, IPCPlus4;
  logic [4:0]    IWriteReg, ReadReg1, ReadReg2;
  logic          ICRegWrite;
  logic [1:0]    ICMemtoReg;
  logic [31:0]   ReadData1, ReadData2, WBData;
  logic [4:0]    WBWriteReg;
  logic          WBRegWrite;
  logic [CW-1:0] RetireCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  int          mdl_cnt;

  always #5 clk = ~clk;

  wb_regfile #(
    .SP_INIT (32'h0000_03FC),
    .GP_INIT (32'h0000_1800),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IMemData    (IMemData),
    .IALUOut     (IALUOut),
    .IPCPlus4    (IPCPlus4),
    .IWriteReg   (IWriteReg),
    .ICRegWrite  (ICRegWrite),
    .ICMemtoReg  (ICMemtoReg),
    .ReadReg1    (ReadReg1),
    .ReadReg2    (ReadReg2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .WBData      (WBData),
    .WBWriteReg  (WBWriteReg),
    .WBRegWrite  (WBRegWrite),
    .RetireCount (RetireCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive at negedge, check combinational view, then advance the model at posedge.
  task automatic step(input logic rst_n, input logic rw, input logic [1:0] mtr,
                      input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] pc4, input logic [4:0] r1, input logic [4:0] r2);
    bit          exp_we;
    logic [31:0] exp_wb;
    logic [31:0] exp_r1, exp_r2;
    @(negedge clk);
    reset = rst_n; ICRegWrite = rw; ICMemtoReg = mtr; IWriteReg = wr;
    IALUOut = alu; IMemData = mem; IPCPlus4 = pc4; ReadReg1 = r1; ReadReg2 = r2;
    #1;
    exp_we = 1'b0;
    if (rst_n && rw && (wr != 5'd0)) exp_we = 1'b1;
    exp_wb = (mtr == 2'd1) ? mem : (mtr == 2'd2) ? pc4 : alu;
    exp_r1 = (r1 == 5'd0) ? 32'd0 : mdl[r1];
    exp_r2 = (r2 == 5'd0) ? 32'd0 : mdl[r2];
    if (exp_we && (r1 == wr)) exp_r1 = exp_wb;
    if (exp_we && (r2 == wr)) exp_r2 = exp_wb;
    check("ReadData1", ReadData1, exp_r1);
    check("ReadData2", ReadData2, exp_r2);
    check("WBRegWrite", 32'(WBRegWrite), 32'(exp_we));
    check("RetireCount", 32'(RetireCount), 32'(mdl_cnt));
    if (rw) begin
      check("WBData", WBData, exp_wb);
      check("WBWriteReg", 32'(WBWriteReg), 32'(wr));
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl[28] = 32'h0000_1800;
      mdl[29] = 32'h0000_03FC;
      mdl_cnt = 0;
    end else if (exp_we) begin
      mdl[wr] = exp_wb;
      mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b1, 1'b0, 2'bxx, 5'bxxxxx, $urandom, $urandom, $urandom, r1, r2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_cnt = 0;
    reset = 1'b0; ICRegWrite = 1'b0; ICMemtoReg = 2'b00; IWriteReg = 5'd0;
    IALUOut = '0; IMemData = '0; IPCPlus4 = '0; ReadReg1 = '0; ReadReg2 = '0;

    // Reset, then sweep every register; $gp/$sp also against literal values.
    step(1'b0, 1'b1, 2'b00, 5'd7, 32'h1234_5678, 32'h0, 32'h0, 5'd7, 5'd0);
    for (int i = 0; i < 16; i++) idle_read(5'(i), 5'(i + 16));
    idle_read(5'd28, 5'd29);
    check("gp_init", ReadData1, 32'h0000_1800);
    check("sp_init", ReadData2, 32'h0000_03FC);
    check("cnt_after_reset", 32'(RetireCount), 32'd0);

    // Write-back sources into $8.
    step(1'b1, 1'b1, 2'b00, 5'd8, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2);
    idle_read(5'd8, 5'd0);
    step(1'b1, 1'b1, 2'b01, 5'd8, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2);
    idle_read(5'd8, 5'd0);
    step(1'b1, 1'b1, 2'b10, 5'd8, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2);
    idle_read(5'd8, 5'd8);
    check("cnt_three", 32'(RetireCount), 32'd3);
    step(1'b1, 1'b1, 2'b11, 5'd8, 32'h77, 32'hB, 32'hC, 5'd8, 5'd0);

    // Dual-port bypass.
    step(1'b1, 1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd5);
    idle_read(5'd5, 5'd5);

    // $0 writes are dropped.
    step(1'b1, 1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);

    // Reset wins over a simultaneous write.
    step(1'b1, 1'b1, 2'b00, 5'd9, 32'h11, 32'h0, 32'h0, 5'd9, 5'd9);
    step(1'b0, 1'b1, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0, 5'd9, 5'd9);
    idle_read(5'd9, 5'd8);
    step(1'b1, 1'b1, 2'b01, 5'd9, 32'h0, 32'h66, 32'h0, 5'd3, 5'd9);
    idle_read(5'd9, 5'd29);
    check("first_commit_cnt", 32'(RetireCount), 32'd1);

    // Counter wrap: 16 commits from zero, interleaved with idle cycles.
    step(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
           $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
      idle_read(5'($urandom), 5'($urandom));
    end
    idle_read(5'd0, 5'd0);
    check("cnt_wrap", 32'(RetireCount), 32'd0);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wr;
      logic [4:0] r1;
      wr = 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      step(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom), wr,
           $urandom, $urandom, $urandom, r1, ($urandom_range(0, 3) == 0) ? wr : 5'($urandom));
    end
    for (int i = 0; i < 16; i++) idle_read(5'(i), 5'(i + 16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
